// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// Shares one binary-to-Gray conversion stage among NREQ requesters. A
// round-robin arbiter picks one valid requester. Its binary word is converted
// and captured, along with its requester ID, in a single-entry output register.
// The word stays there until the consumer takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. A producer holds valid and data stable until
// that edge. Ready never depends combinationally on the data bits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]    per-requester valid
//   req_ready  [NREQ]    per-requester ready, one-hot or zero
//   req_bin    [NREQ*W]  packed binary words, requester i at [i*W +: W]
//   out_valid            output register holds a word
//   out_ready            consumer accepts the held word
//   out_gray   [W]       Gray code of the held word
//   out_bin    [W]       original binary of the held word
//   out_id     [IDW]     requester that supplied the held word
//   dbg_state            output-register state (0 = EMPTY, 1 = FULL)
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_gray,
    output logic [W-1:0]      out_bin,
    output logic [IDW-1:0]    out_id,
    output logic              dbg_state
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           can_accept;
    logic           in_xfer;
    logic [W-1:0]   sel_bin;
    logic [W-1:0]   sel_gray;

    assign out_valid  = (state == FULL);
    assign dbg_state  = (state == FULL);
    assign can_accept = !out_valid || out_ready;

    // Round-robin search. It starts just after the last granted requester and
    // wraps around. Only req_valid and last_grant feed this logic, so the
    // ready path never depends on req_bin.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // Ready is also held low while reset is asserted. This stops a requester
    // from treating a reset cycle as a completed handshake.
    always_comb begin
        req_ready = '0;
        if (rst_n && grant_found && can_accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign in_xfer  = rst_n && grant_found && can_accept;
    assign sel_bin  = req_bin[int'(grant_idx)*W +: W];
    assign sel_gray = sel_bin ^ (sel_bin >> 1);

    // An input transfer always leaves the register FULL, even when the
    // consumer drains it in the same cycle, so there is no bubble.
    always_comb begin
        state_next = state;
        if (in_xfer) begin
            state_next = FULL;
        end else if (out_valid && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and priority pointer change only on an input transfer. A
    // requester that is refused keeps its place in the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_gray   <= '0;
            out_bin    <= '0;
            out_id     <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (in_xfer) begin
            out_gray   <= sel_gray;
            out_bin    <= sel_bin;
            out_id     <= grant_idx;
            last_grant <= grant_idx;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Directed and randomized stimulus for gray_conv_arbiter. The reference model
// is a priority pointer, a one-word holding register and an expected-word
// queue. It is updated from the handshake rules at each rising edge.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_bin;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_gray;
    logic [W-1:0]      out_bin;
    logic [IDW-1:0]    out_id;
    logic              dbg_state;

    gray_conv_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bin   (req_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_gray;
    logic [W-1:0] m_bin;
    int           m_id;
    int           m_last;
    int           last_granted;                  // -1 when no grant on last edge
    logic [W+IDW-1:0] exp_q[$];                 // {id, bin} of words in flight

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    // First valid requester at or after m_last+1, wrapping; -1 if none.
    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_gray  = '0;
        m_bin   = '0;
        m_id    = 0;
        m_last  = NREQ - 1;
        last_granted = -1;
        exp_q.delete();
    endtask

    // One clock: check at the falling edge, update the model at the rising
    // edge, and return 1 ns after the rising edge so the caller can drive.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_ready;
        logic [W+IDW-1:0] w;
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (g >= 0 && (!m_valid || out_ready)) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("dbg_state", 32'(dbg_state), 32'(m_valid));
        if (m_valid) begin
            chk("out_gray", 32'(out_gray), 32'(m_gray));
            chk("out_bin", 32'(out_bin), 32'(m_bin));
            chk("out_id", 32'(out_id), 32'(m_id));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_word", 32'({out_id, out_bin}), 32'(w));
                end
            end
        end
        @(posedge clk);
        last_granted = -1;
        if (g >= 0 && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m_bin   = req_bin[g*W +: W];
            m_gray  = to_gray(m_bin);
            m_id    = g;
            m_last  = g;
            last_granted = g;
            exp_q.push_back({IDW'(g), m_bin});
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = NREQ'($urandom);
        req_bin   = (NREQ*W)'({$urandom, $urandom});
        out_ready = 1'($urandom);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_gray", 32'(out_gray), 32'd0);
        chk("rst_out_bin", 32'(out_bin), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        rst_n     = 1'b0;
        req_valid = '0;
        req_bin   = '0;
        out_ready = 1'b0;
        model_reset();
        #3;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // Exhaustive conversion through requester 2
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            req_valid = 4'b0100;
            req_bin[2*W +: W] = W'(v);
            cycle();
        end
        req_valid = '0;
        cycle();
        cycle();
        // Spot checks against known Gray values
        req_valid = 4'b0100;
        req_bin[2*W +: W] = 4'b0011;
        cycle();
        chk("gray_0011", 32'(out_gray), 32'b0010);
        req_bin[2*W +: W] = 4'b0111;
        cycle();
        chk("gray_0111", 32'(out_gray), 32'b0100);
        req_bin[2*W +: W] = 4'b1000;
        cycle();
        chk("gray_1000", 32'(out_gray), 32'b1100);
        req_bin[2*W +: W] = 4'b1111;
        cycle();
        chk("gray_1111", 32'(out_gray), 32'b1000);
        chk("gray_id2", 32'(out_id), 32'd2);
        req_valid = '0;
        cycle();

        // Round robin: all four valid, no bubbles
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_bin[i*W +: W] = W'(i + 1);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_id", 32'(out_id), 32'(i % NREQ));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end
        req_valid = '0;
        cycle();

        // Backpressure: requester 1 word held, then requester 3 wins
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        req_bin[1*W +: W] = 4'b0110;
        cycle();
        out_ready = 1'b0;
        req_valid = 4'b1001;
        req_bin[0 +: W] = 4'b0001;
        req_bin[3*W +: W] = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_gray", 32'(out_gray), 32'b0101);
            chk("bp_bin", 32'(out_bin), 32'b0110);
            chk("bp_id", 32'(out_id), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release_id", 32'(out_id), 32'd3);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();

        // Fairness under partial load
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001;
        cycle();
        cycle();
        req_valid = 4'b0101;
        req_bin[2*W +: W] = 4'b1001;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (last_granted != 2 && waited < 10);
        chk("fair_wait_le2", 32'(waited <= 2), 32'd1);
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle();
        req_valid = 4'b0101;
        cycle();
        chk("fair_hold_ptr", 32'(out_id), 32'd0);
        req_valid = '0;
        cycle();

        // Mid-operation asynchronous reset while FULL and stalled
        out_ready = 1'b1;
        req_valid = 4'b0010;
        cycle();
        out_ready = 1'b0;
        req_valid = '0;
        cycle();
        chk("mid_full", 32'(out_valid), 32'd1);
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1001;
        cycle();
        chk("mid_first_id", 32'(out_id), 32'd0);
        req_valid = '0;
        cycle();

        // Randomized traffic under the hold-until-handshake rule
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && i != last_granted)) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_bin[i*W +: W] = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = '0;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Shares one binary-to-Gray conversion stage among NREQ requesters using round-robin arbitration and valid/ready handshakes on both sides. Each accepted word is converted and held in a single-entry output register, tagged with the source requester ID, until the downstream consumer takes it. The block sits between several producers of binary codes and one Gray-code consumer, such as a position encoder bus or a CDC pointer path.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, code width in bits (>=2)
IDW, $clog2(NREQ), width of requester ID field (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester valid
req_ready  output  NREQ  per-requester ready; one-hot or zero
req_bin  input  NREQ*W  packed binary words; requester i occupies bits [i*W +: W]
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts word
out_gray  output  W  Gray code of the held word
out_bin  output  W  original binary of the held word
out_id  output  IDW  index of the requester that supplied the word

Behaviour:
- Conversion: gray[W-1] = bin[W-1]; gray[i] = bin[i+1] ^ bin[i] for i < W-1. Computed on the selected req_bin and registered together with bin and ID.
- Register states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- can_accept = !out_valid || out_ready.
- Grant:
  - Combinational round-robin over req_valid.
  - Search starts at (last_grant+1) mod NREQ and wraps.
  - The first asserted req_valid wins.
  - req_ready[g] = can_accept for the winner only; all other bits are 0.
  - If no req_valid is asserted, req_ready = 0.
- Transfers:
  - Input transfer occurs when req_valid[g] && req_ready[g].
  - On the next clock edge, out_gray, out_bin, out_id and out_valid = 1 are loaded, and last_grant <= g.
- Output transfer occurs when out_valid && out_ready.
  - With no simultaneous input transfer: out_valid <= 0 (EMPTY).
  - With a simultaneous input transfer: the register reloads and stays FULL. Throughput is 1 word/cycle with no bubble.
- Latency: exactly 1 cycle from input transfer to out_valid showing that word.
- Backpressure: while out_valid && !out_ready, all req_ready = 0 and the output fields stay constant.
- last_grant changes only on input transfer. A denied requester keeps its priority position.
- Requesters must hold req_valid and req_bin stable until their handshake completes.
- The arbiter never drops or duplicates a word.
- Fairness: with all NREQ requesters continuously valid and out_ready = 1, grants rotate 0, 1, …, NREQ-1, 0, … Any waiting requester is served within NREQ input transfers.
- req_ready must not depend combinationally on req_bin. It depends only on req_valid, last_grant, out_valid and out_ready.
- Reset (asynchronous, any time, including mid-handshake):
  - out_valid = 0, out_gray = 0, out_bin = 0, out_id = 0.
  - last_grant = NREQ-1, so requester 0 has highest priority after reset.
  - A word held at reset is discarded.
  - The first clock edge after rst_n deasserts may accept a new word.
- Values outside 0..9 are converted normally; no BCD range checking is done.

Test Plan:
- Reset/idle: rst_n = 0 with random inputs → out_valid = 0, out_gray/out_bin/out_id = 0, req_ready = 0. After release with no req_valid, outputs unchanged.
- Exhaustive conversion: requester 2 presents bin 0..15 with out_ready = 1 → each word appears 1 cycle later. Check out_gray, e.g. 0011 → 0010, 0111 → 0100, 1000 → 1100, 1111 → 1000, with out_id = 2.
- Round-robin: all 4 valid with bins 1, 2, 3, 4 held and out_ready = 1 → out_id sequence 0, 1, 2, 3, 0… on consecutive cycles, no bubbles. Each requester's req_ready is high only in its grant cycle.
- Backpressure: a word is FULL from requester 1 (bin 0110, gray 0101) and out_ready = 0 for 5 cycles while requesters 0 and 3 are valid → outputs hold 0101/0110/1 and req_ready = 0. When out_ready rises, the same-cycle reload grants requester 3, since the search starts after 1.
- Fairness under partial load: requester 0 always valid, requester 2 valid once → requester 2 is granted within 2 transfers. last_grant does not advance on cycles with no transfer.
- Mid-operation reset: assert rst_n = 0 asynchronously between edges while FULL with out_ready = 0 → out_valid drops immediately without a clock. After release, requester 0 wins over a simultaneously valid requester 3.
